// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 10-bit shift-out, ACK check.
// Lines are only ever pulled low; the top level turns each *_drive_low into an open-drain pad.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int REQ_CYCLES     = 25,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       clk_25MHz,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int HOLD_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int HW       = $clog2(HOLD_MAX + 1);
    localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [HW-1:0] INHIBIT_LAST = HW'(INHIBIT_CYCLES - 1);
    localparam logic [HW-1:0] REQ_LAST     = HW'(REQ_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } state_t;

    state_t        state, state_next;
    logic [HW-1:0] hold_cnt, hold_cnt_next;
    logic [TW-1:0] timeout_cnt, timeout_cnt_next;
    logic [3:0]    bit_idx, bit_idx_next;
    logic [9:0]    shift_reg, shift_reg_next;
    logic          data_low, data_low_next;

    logic clk_meta, clk_sync, clk_prev;
    logic data_meta, data_sync;
    logic clk_fall;
    logic timed_out;

    // Synchronizers reset to the idle (released-high) line level so no false edge appears after reset.
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    assign clk_fall  = clk_prev & ~clk_sync;
    assign timed_out = (timeout_cnt >= TIMEOUT_LAST);

    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            timeout_cnt <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            data_low    <= 1'b0;
        end else begin
            state       <= state_next;
            hold_cnt    <= hold_cnt_next;
            timeout_cnt <= timeout_cnt_next;
            bit_idx     <= bit_idx_next;
            shift_reg   <= shift_reg_next;
            data_low    <= data_low_next;
        end
    end

    always_comb begin
        state_next         = state;
        hold_cnt_next      = hold_cnt;
        timeout_cnt_next   = timeout_cnt;
        bit_idx_next       = bit_idx;
        shift_reg_next     = shift_reg;
        data_low_next      = data_low;
        ps2_clk_drive_low  = 1'b0;
        ps2_data_drive_low = 1'b0;
        tx_busy            = 1'b1;
        tx_done            = 1'b0;
        tx_error           = 1'b0;

        // Saturating watchdog on the device clock, restarted by every falling edge.
        if (state == SHIFT || state == ACK || state == WAIT_IDLE) begin
            if (clk_fall) begin
                timeout_cnt_next = '0;
            end else if (timeout_cnt != TIMEOUT_MAX) begin
                timeout_cnt_next = timeout_cnt + 1'b1;
            end
        end

        case (state)
            IDLE: begin
                tx_busy       = 1'b0;
                hold_cnt_next = '0;
                bit_idx_next  = '0;
                data_low_next = 1'b0;
                if (tx_start) begin
                    state_next     = INHIBIT;
                    shift_reg_next = {1'b1, ~^tx_data, tx_data};
                end
            end
            INHIBIT: begin
                ps2_clk_drive_low = 1'b1;
                if (hold_cnt == INHIBIT_LAST) begin
                    state_next    = REQ;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt + 1'b1;
                end
            end
            REQ: begin
                ps2_clk_drive_low  = 1'b1;
                ps2_data_drive_low = 1'b1;
                if (hold_cnt == REQ_LAST) begin
                    state_next       = SHIFT;
                    hold_cnt_next    = '0;
                    timeout_cnt_next = '0;
                    data_low_next    = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt + 1'b1;
                end
            end
            SHIFT: begin
                // Start bit stays asserted until the device's first falling edge.
                ps2_data_drive_low = data_low;
                if (clk_fall) begin
                    data_low_next  = ~shift_reg[0];
                    shift_reg_next = {1'b0, shift_reg[9:1]};
                    bit_idx_next   = bit_idx + 1'b1;
                    if (bit_idx == 4'd9) begin
                        state_next = ACK;
                    end
                end else if (timed_out) begin
                    state_next = ERR;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    state_next = data_sync ? ERR : WAIT_IDLE;
                end else if (timed_out) begin
                    state_next = ERR;
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    state_next = DONE;
                end else if (timed_out) begin
                    state_next = ERR;
                end
            end
            DONE: begin
                tx_done    = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                tx_error   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench for ps2_host_tx with a behavioural PS/2 device on wired-AND lines.
// Expected frames come from the byte itself: LSB-first data, odd parity, stop bit.
module tb_ps2_host_tx;

    localparam int INHIBIT = 2500;
    localparam int REQ     = 25;
    localparam int TIMEOUT = 1000;
    localparam int HALF    = 100;

    localparam int MODE_NORMAL  = 0;
    localparam int MODE_TIMEOUT = 1;
    localparam int MODE_ABORT   = 2;

    typedef struct packed {
        logic       expect_done;
        logic       check_frame;
        logic [9:0] frame;
    } exp_t;

    logic       clk_25MHz = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       ps2_clk_drive_low;
    logic       ps2_data_drive_low;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_line;
    logic ps2_data_line;

    logic [9:0] seen_frame = '0;
    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    logic       busy_check_pending = 1'b0;

    assign ps2_clk_line  = dev_clk & ~ps2_clk_drive_low;
    assign ps2_data_line = dev_data & ~ps2_data_drive_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .REQ_CYCLES(REQ),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_25MHz(clk_25MHz),
        .reset(reset),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .ps2_clk_in(ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_drive_low(ps2_clk_drive_low),
        .ps2_data_drive_low(ps2_data_drive_low),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_error(tx_error)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    function automatic logic [9:0] refFrame(input logic [7:0] d);
        logic parity;
        parity = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, parity, d};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Pops one expectation per completion pulse and checks outcome, frame and line release.
    always @(negedge clk_25MHz) begin : monitor
        exp_t e;
        if (busy_check_pending) begin
            checkOutput("busy_falls_after_pulse", 32'(tx_busy), 32'd0);
            busy_check_pending = 1'b0;
        end
        if (tx_done || tx_error) begin
            checkOutput("done_error_exclusive", 32'(tx_done & tx_error), 32'd0);
            checkOutput("drives_released_at_pulse", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);
            checkOutput("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("outcome_done", 32'(tx_done), 32'(e.expect_done));
                checkOutput("outcome_error", 32'(tx_error), 32'(!e.expect_done));
                if (e.check_frame) begin
                    checkOutput("frame_bits", 32'(seen_frame), 32'(e.frame));
                end
            end
            busy_check_pending = 1'b1;
        end
    end

    task automatic deviceRun(input int mode, input logic ack);
        int inh;
        int rq;
        int guard;
        int cnt;
        inh   = 0;
        rq    = 0;
        guard = 0;
        seen_frame = '0;
        @(negedge clk_25MHz);
        while (ps2_clk_drive_low && !ps2_data_drive_low && guard < 2 * INHIBIT) begin
            inh++;
            guard++;
            @(negedge clk_25MHz);
        end
        while (ps2_clk_drive_low && ps2_data_drive_low && guard < 2 * INHIBIT) begin
            rq++;
            guard++;
            @(negedge clk_25MHz);
        end
        checkOutput("inhibit_length", 32'(inh), 32'(INHIBIT));
        checkOutput("request_length", 32'(rq), 32'(REQ));
        checkOutput("start_bit_held", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'b01);

        if (mode == MODE_TIMEOUT) begin
            cnt = 0;
            while (!tx_error && cnt < 3 * TIMEOUT) begin
                @(negedge clk_25MHz);
                cnt++;
            end
            checkOutput("timeout_cycles", 32'(cnt), 32'(TIMEOUT));
            return;
        end

        repeat (40) @(negedge clk_25MHz);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) begin
                repeat (20) @(negedge clk_25MHz);
                dev_data = ack ? 1'b0 : 1'b1;
                repeat (HALF - 20) @(negedge clk_25MHz);
            end
            dev_clk = 1'b0;
            if (mode == MODE_ABORT && k == 5) begin
                repeat (10) @(negedge clk_25MHz);
                checkOutput("abort_data_held", 32'(ps2_data_drive_low), 32'd1);
                reset = 1'b1;
                @(negedge clk_25MHz);
                checkOutput("abort_drives_released", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);
                checkOutput("abort_busy_cleared", 32'(tx_busy), 32'd0);
                repeat (2) @(negedge clk_25MHz);
                reset   = 1'b0;
                dev_clk = 1'b1;
                return;
            end
            repeat (HALF) @(negedge clk_25MHz);
            dev_clk = 1'b1;
            if (k <= 10) begin
                seen_frame[k-1] = ps2_data_line;
                repeat (HALF) @(negedge clk_25MHz);
            end else begin
                dev_data = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input int mode, input logic ack, input logic interfere);
        exp_t e;
        int   guard;
        @(posedge clk_25MHz);
        #1;
        tx_data  = data;
        tx_start = 1'b1;
        if (mode != MODE_ABORT) begin
            e.expect_done = (mode == MODE_NORMAL) && ack;
            e.check_frame = (mode == MODE_NORMAL);
            e.frame       = refFrame(data);
            exp_q.push_back(e);
        end
        @(posedge clk_25MHz);
        #1;
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        checkOutput("busy_on_accept", 32'(tx_busy), 32'd1);
        if (interfere) begin
            fork
                deviceRun(mode, ack);
                begin
                    repeat (3000) @(negedge clk_25MHz);
                    tx_data  = 8'hAA;
                    tx_start = 1'b1;
                    @(negedge clk_25MHz);
                    tx_start = 1'b0;
                end
            join
        end else begin
            deviceRun(mode, ack);
        end
        guard = 0;
        while (tx_busy && guard < 4 * TIMEOUT) begin
            @(negedge clk_25MHz);
            guard++;
        end
        checkOutput("returns_idle", 32'(tx_busy), 32'd0);
        repeat (300) @(negedge clk_25MHz);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        $display("[TB] transfer 0x%02h mode %0d ack %0d finished", data, mode, ack);
    endtask

    initial begin
        repeat (4) @(negedge clk_25MHz);
        checkOutput("reset_clk_drive", 32'(ps2_clk_drive_low), 32'd0);
        checkOutput("reset_data_drive", 32'(ps2_data_drive_low), 32'd0);
        checkOutput("reset_busy", 32'(tx_busy), 32'd0);
        checkOutput("reset_pulses", 32'({tx_done, tx_error}), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk_25MHz);

        applyStimulus(8'hF4, MODE_NORMAL, 1'b1, 1'b0);
        applyStimulus(8'hFF, MODE_NORMAL, 1'b1, 1'b0);
        applyStimulus(8'h00, MODE_NORMAL, 1'b1, 1'b0);
        applyStimulus(8'h5A, MODE_NORMAL, 1'b0, 1'b0);
        applyStimulus(8'hF4, MODE_TIMEOUT, 1'b0, 1'b0);
        applyStimulus(8'h00, MODE_ABORT, 1'b0, 1'b0);
        applyStimulus(8'hF4, MODE_NORMAL, 1'b1, 1'b0);
        applyStimulus(8'hF4, MODE_NORMAL, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'($urandom), MODE_NORMAL, ($urandom_range(0, 3) != 0), 1'b0);
        end

        repeat (20) @(negedge clk_25MHz);
        checkOutput("final_idle", 32'({tx_busy, ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
